gamma_write_pipe: RTL and testbench

- Pixel write-path stage between axif_interface (o_we/o_waddr/o_wdata/o_wstrb) and the framebuffer write port.
- Applies a per-channel, software-loadable gamma LUT, then a global brightness scale, to every 24-bit RGB word written over AXI-Full.
- Forwards address and strobes aligned to the corrected data, with fixed 3-cycle latency and no backpressure.
- Exposes a busy flag so buffer-swap logic can wait for the pipe to drain.

---
 rtl/ledcube_pkg.sv | 32 +++
 rtl/gamma_lut.sv | 32 +++
 rtl/gamma_write_pipe.sv | 117 +++++++++++
 tb/tb_gamma_write_pipe.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ledcube_pkg.sv
// Shared constants for the LED-cube pixel path: LUT channel selects,
// RGB field offsets within a 32-bit pixel word and the default channel depth.
package ledcube_pkg;

    localparam int BPC_DEFAULT = 8;
    localparam int N_CH        = 3;

    typedef enum logic [1:0] {
        CH_R   = 2'd0,
        CH_G   = 2'd1,
        CH_B   = 2'd2,
        CH_ALL = 2'd3
    } lut_sel_e;

    localparam int R_LSB = 16;
    localparam int G_LSB = 8;
    localparam int B_LSB = 0;

    // Channel index 0/1/2 maps to R/G/B, matching the LUT select encoding.
    function automatic int chan_lsb(input int ch);
        case (ch)
            0:       return R_LSB;
            1:       return G_LSB;
            default: return B_LSB;
        endcase
    endfunction

    function automatic logic lut_sel_hit(input logic [1:0] sel, input int ch);
        return (sel == CH_ALL) || (int'(sel) == ch);
    endfunction

endpackage

// File: rtl/gamma_lut.sv
// One gamma channel: 2^BPC x BPC simple dual-port RAM, one write port and
// one registered read port with read-before-write behaviour.
module gamma_lut #(
    parameter int BPC = 8
) (
    input  logic           clk,
    input  logic           we,
    input  logic [BPC-1:0] waddr,
    input  logic [BPC-1:0] wdata,
    input  logic [BPC-1:0] raddr,
    output logic [BPC-1:0] rdata
);

    localparam int DEPTH = 1 << BPC;

    // Entries are stored XORed with their own index so that a RAM which
    // powers up all-zero presents an identity table without any init pass.
    logic [BPC-1:0] mem [DEPTH];
    logic [BPC-1:0] rd_word_reg;
    logic [BPC-1:0] rd_addr_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata ^ waddr;
        end
        rd_word_reg <= mem[raddr];
        rd_addr_reg <= raddr;
    end

    assign rdata = rd_word_reg ^ rd_addr_reg;

endmodule

// File: rtl/gamma_write_pipe.sv
// Framebuffer write-path stage: per-channel gamma LUT followed by a global
// brightness scale, 3-cycle fixed latency, address/strobes kept aligned.
module gamma_write_pipe #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32,
    parameter int BPC        = ledcube_pkg::BPC_DEFAULT
) (
    input  logic                    clk,
    input  logic                    aresetn,
    input  logic                    i_we,
    input  logic [ADDR_WIDTH-1:0]   i_waddr,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_wstrb,
    input  logic                    i_bypass,
    input  logic [7:0]              i_brightness,
    input  logic                    i_lut_we,
    input  logic [1:0]              i_lut_sel,
    input  logic [BPC-1:0]          i_lut_addr,
    input  logic [BPC-1:0]          i_lut_data,
    output logic                    o_we,
    output logic [ADDR_WIDTH-1:0]   o_waddr,
    output logic [DATA_WIDTH-1:0]   o_wdata,
    output logic [DATA_WIDTH/8-1:0] o_wstrb,
    output logic                    o_busy
);
    import ledcube_pkg::*;

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int PIX_WIDTH  = N_CH * BPC;

    logic [BPC-1:0]       lut_rdata [N_CH];
    logic [BPC-1:0]       chan_next [N_CH];
    logic [PIX_WIDTH-1:0] pix_next;
    logic                 unused_hi_bits;

    logic                  s1_valid_reg, s2_valid_reg, s3_valid_reg;
    logic [ADDR_WIDTH-1:0] s1_addr_reg, s2_addr_reg, s3_addr_reg;
    logic [STRB_WIDTH-1:0] s1_strb_reg, s2_strb_reg, s3_strb_reg;
    logic                  s1_bypass_reg;
    logic [7:0]            s1_bright_reg;
    logic [PIX_WIDTH-1:0]  s1_pix_reg, s2_pix_reg, s3_pix_reg;

    assign unused_hi_bits = ^i_wdata[DATA_WIDTH-1:PIX_WIDTH];

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_chan
            localparam int LSB = chan_lsb(gi);
            logic [BPC+8:0] product;

            gamma_lut #(.BPC(BPC)) u_lut (
                .clk   (clk),
                .we    (i_lut_we && lut_sel_hit(i_lut_sel, gi)),
                .waddr (i_lut_addr),
                .wdata (i_lut_data),
                .raddr (i_wdata[LSB +: BPC]),
                .rdata (lut_rdata[gi])
            );

            // brightness+1 makes 255 an exact unity gain after the >>8.
            assign product = (BPC+9)'(lut_rdata[gi]) *
                             (BPC+9)'({1'b0, s1_bright_reg} + 9'd1);
            assign chan_next[gi] = s1_bypass_reg ? s1_pix_reg[LSB +: BPC]
                                                 : BPC'(product >> 8);
        end
    endgenerate

    always_comb begin
        pix_next = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            pix_next[chan_lsb(ch) +: BPC] = chan_next[ch];
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            s1_valid_reg  <= 1'b0;
            s1_addr_reg   <= '0;
            s1_strb_reg   <= '0;
            s1_bypass_reg <= 1'b0;
            s1_bright_reg <= '0;
            s1_pix_reg    <= '0;
            s2_valid_reg  <= 1'b0;
            s2_addr_reg   <= '0;
            s2_strb_reg   <= '0;
            s2_pix_reg    <= '0;
            s3_valid_reg  <= 1'b0;
            s3_addr_reg   <= '0;
            s3_strb_reg   <= '0;
            s3_pix_reg    <= '0;
        end else begin
            s1_valid_reg  <= i_we;
            s1_addr_reg   <= i_waddr;
            s1_strb_reg   <= i_wstrb;
            s1_bypass_reg <= i_bypass;
            s1_bright_reg <= i_brightness;
            s1_pix_reg    <= i_wdata[PIX_WIDTH-1:0];

            s2_valid_reg  <= s1_valid_reg;
            s2_addr_reg   <= s1_addr_reg;
            s2_strb_reg   <= s1_strb_reg;
            s2_pix_reg    <= pix_next;

            s3_valid_reg  <= s2_valid_reg;
            s3_addr_reg   <= s2_addr_reg;
            s3_strb_reg   <= s2_strb_reg;
            s3_pix_reg    <= s2_pix_reg;
        end
    end

    assign o_we    = s3_valid_reg;
    assign o_waddr = s3_addr_reg;
    assign o_wstrb = s3_strb_reg;
    assign o_wdata = {{(DATA_WIDTH-PIX_WIDTH){1'b0}}, s3_pix_reg};
    assign o_busy  = s1_valid_reg | s2_valid_reg | s3_valid_reg;

endmodule

// File: tb/tb_gamma_write_pipe.sv
// Scoreboard bench for gamma_write_pipe: stimulus pushes expected writes
// computed from a LUT/brightness model, a negedge monitor pops and compares.
module tb_gamma_write_pipe;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        i_we;
    logic [13:0] i_waddr;
    logic [31:0] i_wdata;
    logic [3:0]  i_wstrb;
    logic        i_bypass;
    logic [7:0]  i_brightness;
    logic        i_lut_we;
    logic [1:0]  i_lut_sel;
    logic [7:0]  i_lut_addr;
    logic [7:0]  i_lut_data;
    logic        o_we;
    logic [13:0] o_waddr;
    logic [31:0] o_wdata;
    logic [3:0]  o_wstrb;
    logic        o_busy;

    always #5 clk = ~clk;

    gamma_write_pipe #(.ADDR_WIDTH(14), .DATA_WIDTH(32), .BPC(8)) dut (
        .clk          (clk),
        .aresetn      (aresetn),
        .i_we         (i_we),
        .i_waddr      (i_waddr),
        .i_wdata      (i_wdata),
        .i_wstrb      (i_wstrb),
        .i_bypass     (i_bypass),
        .i_brightness (i_brightness),
        .i_lut_we     (i_lut_we),
        .i_lut_sel    (i_lut_sel),
        .i_lut_addr   (i_lut_addr),
        .i_lut_data   (i_lut_data),
        .o_we         (o_we),
        .o_waddr      (o_waddr),
        .o_wdata      (o_wdata),
        .o_wstrb      (o_wstrb),
        .o_busy       (o_busy)
    );

    typedef struct {
        logic [13:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   lut_m [3][256];
    int   cycle = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_out = 0;
    int   last_issue = 0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    endtask

    // Reference: gamma lookup then scale by (brightness+1)/256, or raw pass-through.
    function automatic logic [31:0] model_pix(input logic [31:0] d, input logic byp,
                                              input logic [7:0] br);
        logic [31:0] r;
        r = '0;
        for (int ch = 0; ch < 3; ch++) begin
            int c;
            int v;
            c = int'(d[16 - 8*ch +: 8]);
            v = byp ? c : (lut_m[ch][c] * (int'(br) + 1)) / 256;
            r[16 - 8*ch +: 8] = v[7:0];
        end
        return r;
    endfunction

    task automatic issue(input logic we, input logic [13:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input logic byp, input logic [7:0] br,
                         input logic lwe, input logic [1:0] lsel, input logic [7:0] la,
                         input logic [7:0] ld);
        exp_t e;
        i_we = we; i_waddr = addr; i_wdata = data; i_wstrb = strb;
        i_bypass = byp; i_brightness = br;
        i_lut_we = lwe; i_lut_sel = lsel; i_lut_addr = la; i_lut_data = ld;
        if (we) begin
            e.addr = addr; e.data = model_pix(data, byp, br); e.strb = strb; e.cyc = cycle + 3;
            sb.push_back(e);
            last_issue = cycle;
        end
        // Model updated after the expectation: a same-cycle pixel sees the old entry.
        if (lwe) begin
            for (int ch = 0; ch < 3; ch++)
                if (lsel == 2'd3 || int'(lsel) == ch) lut_m[ch][la] = int'(ld);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        i_we = 1'b0;
        i_lut_we = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    always @(negedge clk) begin
        if (o_we) begin
            exp_t e;
            n_out++;
            if (sb.size() == 0) begin
                check("unexpected_write", {63'b0, o_we}, 64'd0);
            end else begin
                e = sb.pop_front();
                $display("out cyc=%0d addr=%h data=%h strb=%h", cycle, o_waddr, o_wdata, o_wstrb);
                check("wdata", {32'b0, o_wdata}, {32'b0, e.data});
                check("addr_strb_time", {14'b0, o_waddr, o_wstrb, cycle}, {14'b0, e.addr, e.strb, e.cyc});
            end
        end
    end

    initial begin
        int out_before;
        for (int ch = 0; ch < 3; ch++)
            for (int i = 0; i < 256; i++) lut_m[ch][i] = i;
        aresetn = 1'b0;
        i_we = 0; i_waddr = 0; i_wdata = 0; i_wstrb = 0; i_bypass = 0; i_brightness = 8'd255;
        i_lut_we = 0; i_lut_sel = 0; i_lut_addr = 0; i_lut_data = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_we",    {63'b0, o_we}, 64'd0);
        check("rst_busy",  {63'b0, o_busy}, 64'd0);
        check("rst_waddr", {50'b0, o_waddr}, 64'd0);
        check("rst_wdata", {32'b0, o_wdata}, 64'd0);
        check("rst_wstrb", {60'b0, o_wstrb}, 64'd0);
        aresetn = 1'b1;
        idle(2);

        // Identity LUT at unity brightness.
        issue(1, 14'h0012, 32'h00FF8040, 4'hF, 0, 8'd255, 0, 2'd0, 8'h00, 8'h00);
        idle(5);

        // R entry 0x80 -> 0x10, G and B untouched.
        issue(0, 14'h0, 32'h0, 4'h0, 0, 8'd255, 1, 2'd0, 8'h80, 8'h10);
        issue(1, 14'h0020, 32'h00808080, 4'h7, 0, 8'd255, 0, 2'd0, 8'h00, 8'h00);
        idle(5);

        // Brightness 127 on identity entries (G 0x40, R/B 0xFF).
        issue(1, 14'h0030, 32'h00FF40FF, 4'hF, 0, 8'd127, 0, 2'd0, 8'h00, 8'h00);
        idle(5);

        // 16-beat burst with one bubble, then drain timing of o_busy.
        for (int b = 0; b < 16; b++) begin
            if (b == 8) idle(1);
            issue(1, 14'(14'h0100 + b), $urandom(), 4'($urandom()), 0, 8'd255, 0, 2'd0, 8'h00, 8'h00);
        end
        i_we = 1'b0;
        for (int k = 0; k < 10 && cycle != last_issue + 3; k++) @(negedge clk);
        check("busy_wait", 64'(cycle), 64'(last_issue + 3));
        check("busy_last_out", {63'b0, o_busy}, 64'd1);
        @(negedge clk);
        check("busy_drained", {63'b0, o_busy}, 64'd0);
        @(posedge clk); #1;

        // Same-cycle LUT write and read of B entry 0x33.
        issue(1, 14'h0200, 32'h00000033, 4'hF, 0, 8'd255, 1, 2'd2, 8'h33, 8'h99);
        issue(1, 14'h0201, 32'h00000033, 4'hF, 0, 8'd255, 0, 2'd0, 8'h00, 8'h00);
        idle(5);

        // Bypass with brightness 0, then brightness 0 without bypass.
        issue(1, 14'h0300, 32'hAAABCDEF, 4'hF, 1, 8'd0, 0, 2'd0, 8'h00, 8'h00);
        issue(1, 14'h0301, 32'h00ABCDEF, 4'hF, 0, 8'd0, 0, 2'd0, 8'h00, 8'h00);
        idle(5);

        // Randomised traffic with interleaved LUT loads (sel 0..3).
        for (int n = 0; n < 300; n++) begin
            issue(($urandom() % 4) != 0, 14'($urandom()), $urandom(), 4'($urandom()),
                  ($urandom() % 8) == 0, 8'($urandom()), ($urandom() % 4) == 0,
                  2'($urandom()), 8'($urandom()), 8'($urandom()));
        end
        idle(6);

        // Reset with two writes in flight: none may emerge.
        issue(1, 14'h0400, 32'h00123456, 4'hF, 0, 8'd255, 0, 2'd0, 8'h00, 8'h00);
        issue(1, 14'h0401, 32'h00654321, 4'hF, 0, 8'd255, 0, 2'd0, 8'h00, 8'h00);
        i_we = 1'b0;
        aresetn = 1'b0;
        sb.delete();
        out_before = n_out;
        #1;
        check("midrst_we",   {63'b0, o_we}, 64'd0);
        check("midrst_busy", {63'b0, o_busy}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        aresetn = 1'b1;
        idle(8);
        check("no_stale_write", 64'(n_out), 64'(out_before));

        // Post-reset sanity write; LUT contents survive reset.
        issue(1, 14'h3FFF, 32'h00808033, 4'h5, 0, 8'd200, 0, 2'd0, 8'h00, 8'h00);
        idle(6);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
